// File: rtl/scan_mux_pkg.sv
// Shared types for scan_mux: controller state encoding.
package scan_mux_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/dwell_counter.sv
// Counts 0..DWELL-1 while en is high; tc pulses on the last count and the counter restarts.
module dwell_counter #(
  parameter int DWELL = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with manual select or dwell-timed auto-scan; one cycle latency.
// Optional registered parity output when SCAN_MUX_PARITY_EN is defined.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           ch_out,
  output logic                      valid,
`ifdef SCAN_MUX_PARITY_EN
  output logic                      parity,
`endif
  output logic                      wrap
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic            scan_run;
  logic            dwell_tc;

  // Counter only runs while scan continues; any entry into SCAN restarts it.
  assign scan_run = (state_q == SCAN) && (state_d == SCAN);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (!scan_run),
    .en  (scan_run),
    .tc  (dwell_tc)
  );

  always_comb begin
    if (!en) begin
      state_d = IDLE;
    end else if (mode) begin
      state_d = SCAN;
    end else begin
      state_d = MANUAL;
    end
  end

  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ptr_d   = '0;
    case (state_d)
      MANUAL: begin
        ch_d = sel;
        if (int'(sel) < CHANNELS) begin
          dout_d  = din[int'(sel)*WIDTH +: WIDTH];
          valid_d = 1'b1;
        end else begin
          dout_d = '0;
        end
      end
      SCAN: begin
        if (scan_run) begin
          ptr_d = ptr_q;
          if (dwell_tc) begin
            ptr_d  = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
            wrap_d = (ptr_q == LAST_CH);
          end
        end
        // Output follows the live input of the channel being shown.
        ch_d    = ptr_d;
        dout_d  = din[int'(ptr_d)*WIDTH +: WIDTH];
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout   = dout_q;
  assign ch_out = ch_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;

`ifdef SCAN_MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= valid_d ? ^dout_d : 1'b0;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: 4-channel/DWELL=8 instance plus a 3-channel/DWELL=1 instance.
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  dout;
  logic [1:0]  ch_out;
  logic        valid;
  logic        wrap;

  logic [11:0] din3 = '0;
  logic [1:0]  sel3 = '0;
  logic        mode3 = 1'b0;
  logic        en3 = 1'b0;
  logic [3:0]  dout3;
  logic [1:0]  ch_out3;
  logic        valid3;
  logic        wrap3;

`ifdef SCAN_MUX_PARITY_EN
  logic parity;
  logic parity3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(8)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
    .dout(dout), .ch_out(ch_out), .valid(valid),
`ifdef SCAN_MUX_PARITY_EN
    .parity(parity),
`endif
    .wrap(wrap)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel3), .mode(mode3), .en(en3),
    .dout(dout3), .ch_out(ch_out3), .valid(valid3),
`ifdef SCAN_MUX_PARITY_EN
    .parity(parity3),
`endif
    .wrap(wrap3)
  );

  typedef struct {
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] din;
    logic [3:0]  exp_dout;
    logic [1:0]  exp_ch;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] chan4(input logic [15:0] d, input int ch);
    logic [15:0] t;
    t = d >> (4 * ch);
    return t[3:0];
  endfunction

  function automatic logic [3:0] chan3(input logic [11:0] d, input int ch);
    logic [11:0] t;
    t = d >> (4 * ch);
    return t[3:0];
  endfunction

  task automatic check_scan(input string tag, input int ch, input logic exp_wrap);
    check({tag, "_ch"}, 32'(ch_out), 32'(ch));
    check({tag, "_dout"}, 32'(dout), 32'(chan4(din, ch)));
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd2, 16'hDCBA, 4'hC, 2'd2, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'd3, 16'hDCBA, 4'hD, 2'd3, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 16'hDCBA, 4'hB, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 16'hDCBA, 4'hB, 2'd1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 16'h1234, 4'h3, 2'd1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 2'd3, 16'h1234, 4'h1, 2'd3, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 16'h1234, 4'h4, 2'd0, 1'b1};

    // Reset, then idle with en low.
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_dout", 32'(dout), 32'd0);
      check("idle_ch", 32'(ch_out), 32'd0);
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_wrap", 32'(wrap), 32'd0);
      check("idle3_valid", 32'(valid3), 32'd0);
    end

    // Manual-mode table.
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en;
      mode = vecs[i].mode;
      sel = vecs[i].sel;
      din = vecs[i].din;
      tick();
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_ch", i), 32'(ch_out), 32'(vecs[i].exp_ch));
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'd0);
    end

    // MANUAL -> SCAN entry starts at channel 0, then back to MANUAL.
    din = 16'hDCBA;
    sel = 2'd3;
    mode = 1'b1;
    tick();
    check_scan("m2s", 0, 1'b0);
    mode = 1'b0;
    sel = 2'd2;
    tick();
    check("s2m_dout", 32'(dout), 32'hC);
    check("s2m_ch", 32'(ch_out), 32'd2);
    en = 1'b0;
    tick();

    // Full sweep from IDLE with a live din change mid-dwell.
    en = 1'b1;
    mode = 1'b1;
    tick();
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        if (c == 20) din = 16'h5678;
        tick();
      end
      check_scan($sformatf("sweep%0d", c), (c / 8) % 4, (c > 0) && (c % 32 == 0));
    end

    // en falls exactly on the wrap edge: IDLE wins.
    din = 16'hDCBA;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int c = 1; c <= 31; c++) tick();
    check_scan("prewrap", 3, 1'b0);
    en = 1'b0;
    tick();
    check("enfall_wrap", 32'(wrap), 32'd0);
    check("enfall_valid", 32'(valid), 32'd0);
    check("enfall_ch", 32'(ch_out), 32'd3);
    check("enfall_dout", 32'(dout), 32'hD);

    // Async reset while showing channel 2, then restart with full dwell.
    en = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) tick();
    check_scan("prerst", 2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_ch", 32'(ch_out), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      check_scan($sformatf("postrst%0d", c), (c < 8) ? 0 : 1, 1'b0);
    end
    en = 1'b0;
    tick();

`ifdef SCAN_MUX_PARITY_EN
    en = 1'b1;
    mode = 1'b0;
    sel = 2'd1;
    din = 16'h0070;
    tick();
    check("parity_odd", 32'(parity), 32'd1);
    din = 16'h0030;
    tick();
    check("parity_even", 32'(parity), 32'd0);
    din = 16'h0070;
    en = 1'b0;
    tick();
    check("parity_idle", 32'(parity), 32'd0);
`endif

    // Three-channel instance: out-of-range select, then DWELL=1 scan.
    din3 = 12'hCBA;
    en3 = 1'b1;
    mode3 = 1'b0;
    sel3 = 2'd3;
    tick();
    check("oor_dout", 32'(dout3), 32'd0);
    check("oor_valid", 32'(valid3), 32'd0);
    check("oor_ch", 32'(ch_out3), 32'd3);
    sel3 = 2'd2;
    tick();
    check("ch3_sel2_dout", 32'(dout3), 32'hC);
    check("ch3_sel2_valid", 32'(valid3), 32'd1);
    sel3 = 2'd3;
    tick();
    check("oor2_dout", 32'(dout3), 32'd0);
    check("oor2_valid", 32'(valid3), 32'd0);
    mode3 = 1'b1;
    tick();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      check($sformatf("d1_%0d_ch", c), 32'(ch_out3), 32'(c % 3));
      check($sformatf("d1_%0d_dout", c), 32'(dout3), 32'(chan3(din3, c % 3)));
      check($sformatf("d1_%0d_wrap", c), 32'(wrap3), 32'((c > 0) && (c % 3 == 0)));
    end
    en3 = 1'b0;
    tick();
    check("d1_enfall_wrap", 32'(wrap3), 32'd0);
    check("d1_enfall_valid", 32'(valid3), 32'd0);
    check("d1_enfall_ch", 32'(ch_out3), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
